// File: rtl/iic_pkg.sv
// Shared constants and types for the IIC SCL timing engine.
package iic_pkg;

   // Quarter encodings: two low quarters followed by two high quarters.
   localparam logic [1:0] PH_LOW0  = 2'd0;
   localparam logic [1:0] PH_LOW1  = 2'd1;
   localparam logic [1:0] PH_HIGH0 = 2'd2;
   localparam logic [1:0] PH_HIGH1 = 2'd3;

   // Default parameterisation of the timing engine.
   localparam int DEFAULT_CNT_WIDTH   = 16;
   localparam int DEFAULT_DIV_VAL     = 124;
   localparam int DEFAULT_MIN_DIV     = 2;
   localparam int DEFAULT_SYNC_STAGES = 2;

   // Engine state: idle (SCL released) or running the quarter sequence.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_state_e;

endpackage : iic_pkg

// File: rtl/iic_sync2.sv
// Multi-flop synchroniser for the asynchronous SCL pad input.
// Resets to 1 so a released bus reads as high straight out of reset.
module iic_sync2 #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic sync_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw pad value through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         for (int i = STAGES - 1; i > 0; i--) begin
            sync_q[i] <= sync_q[i-1];
         end
         sync_q[0] <= async_i;
      end
   end

   assign sync_o = sync_q[STAGES-1];

endmodule : iic_sync2

// File: rtl/iic_scl_timing_gen.sv
// IIC bit-timing engine: splits each SCL period into four equal quarters,
// drives SCL open-drain and holds the high phase while a slave stretches.
// MIN_DIV must be >= SYNC_STAGES so the stretch check point always lies
// inside the first high quarter.
module iic_scl_timing_gen
   import iic_pkg::*;
#(
   parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
   parameter int DEFAULT_DIV = DEFAULT_DIV_VAL,
   parameter int MIN_DIV     = DEFAULT_MIN_DIV,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [CNT_WIDTH-1:0] div_cfg,
   input  logic                 stretch_en,
   input  logic                 scl_in,
   output logic                 scl_oe,
   output logic [1:0]           phase,
   output logic                 quarter_pulse,
   output logic                 scl_fall_pulse,
   output logic                 scl_rise_pulse,
   output logic                 stretch_active
);

   localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(DEFAULT_DIV);
   localparam logic [CNT_WIDTH-1:0] DIV_MIN = CNT_WIDTH'(MIN_DIV);
   localparam logic [CNT_WIDTH-1:0] CHK_CNT = CNT_WIDTH'(SYNC_STAGES);

   run_state_e           state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0]           phase_q, phase_d;
   logic [CNT_WIDTH-1:0] div_q, div_d;
   logic                 scl_oe_q, scl_oe_d;
   logic                 qpulse_q, qpulse_d;
   logic                 fpulse_q, fpulse_d;

   logic                 scl_sync;
   logic [CNT_WIDTH-1:0] div_clamped;
   logic                 at_check;
   logic                 scl_high_seen;
   logic                 stretch_hold;

   iic_sync2 #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (scl_in),
      .sync_o  (scl_sync)
   );

   // Requested divider with the floor applied; only sampled at safe points.
   assign div_clamped = (div_cfg < DIV_MIN) ? DIV_MIN : div_cfg;

   // The check point sits SYNC_STAGES clocks into the first high quarter,
   // which is exactly when a released SCL has crossed the synchroniser.
   assign at_check      = (state_q == ST_RUN) && (phase_q == PH_HIGH0) && (cnt_q == CHK_CNT);
   assign scl_high_seen = !stretch_en || scl_sync;
   assign stretch_hold  = at_check && !scl_high_seen;

   // State register: counter, phase, divider and registered pad/strobe outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         phase_q  <= PH_LOW0;
         div_q    <= DIV_RST;
         scl_oe_q <= 1'b0;
         qpulse_q <= 1'b0;
         fpulse_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         div_q    <= div_d;
         scl_oe_q <= scl_oe_d;
         qpulse_q <= qpulse_d;
         fpulse_q <= fpulse_d;
      end
   end

   // Next-state logic: idle/abort, start-up, stretch hold and quarter advance.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      div_d    = div_q;
      scl_oe_d = scl_oe_q;
      qpulse_d = 1'b0;
      fpulse_d = 1'b0;

      if (!en) begin
         // Disabled: everything returns to a released, clean state and the
         // divider tracks the requested value.
         state_d  = ST_IDLE;
         cnt_d    = '0;
         phase_d  = PH_LOW0;
         div_d    = div_clamped;
         scl_oe_d = 1'b0;
      end else if (state_q == ST_IDLE) begin
         // First enabled cycle: pull SCL low and open quarter 0.
         state_d  = ST_RUN;
         cnt_d    = '0;
         phase_d  = PH_LOW0;
         scl_oe_d = 1'b1;
         qpulse_d = 1'b1;
         fpulse_d = 1'b1;
      end else if (stretch_hold) begin
         // Slave still holds SCL low: freeze the counter at the check point.
         cnt_d = cnt_q;
      end else if (cnt_q == div_q) begin
         cnt_d    = '0;
         phase_d  = phase_q + 2'd1;
         qpulse_d = 1'b1;
         if (phase_q == PH_HIGH1) begin
            // Period boundary: the only running point where the divider may change.
            fpulse_d = 1'b1;
            div_d    = div_clamped;
         end
         scl_oe_d = (phase_d == PH_LOW0) || (phase_d == PH_LOW1);
      end else begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   // Output logic: registered pad/strobes plus the check-point indications.
   always_comb begin
      scl_oe         = scl_oe_q;
      phase          = phase_q;
      quarter_pulse  = qpulse_q;
      scl_fall_pulse = fpulse_q;
      scl_rise_pulse = at_check && scl_high_seen;
      stretch_active = stretch_hold;
   end

endmodule : iic_scl_timing_gen

// File: tb/tb_iic_scl_timing_gen.sv
// Directed bench for the IIC SCL timing engine.
module tb_iic_scl_timing_gen;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [15:0] div_cfg;
   logic        stretch_en;
   logic        scl_in;
   logic        scl_oe;
   logic [1:0]  phase;
   logic        quarter_pulse;
   logic        scl_fall_pulse;
   logic        scl_rise_pulse;
   logic        stretch_active;

   logic        scl_low;     // models a slave holding SCL low
   int          pass_cnt;
   int          chk_cnt;

   // Observed vector: {scl_oe, phase[1:0], quarter, fall, rise, stretch}
   logic [6:0]  obs;
   assign obs = {scl_oe, phase, quarter_pulse, scl_fall_pulse, scl_rise_pulse, stretch_active};

   // Open-drain bus: low if the master or the slave pulls it.
   assign scl_in = ~scl_oe & ~scl_low;

   iic_scl_timing_gen dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .div_cfg        (div_cfg),
      .stretch_en     (stretch_en),
      .scl_in         (scl_in),
      .scl_oe         (scl_oe),
      .phase          (phase),
      .quarter_pulse  (quarter_pulse),
      .scl_fall_pulse (scl_fall_pulse),
      .scl_rise_pulse (scl_rise_pulse),
      .stretch_active (stretch_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs k cycles after enable for an unstretched run with
   // quarter length q, SCL following the master.
   function automatic logic [6:0] exp_norm(input int k, input int q);
      int         qi;
      int         pos;
      logic [1:0] ph;
      logic       oe;
      logic       qp;
      logic       fp;
      logic       rs;
      qi  = k / q;
      pos = k % q;
      ph  = 2'(qi % 4);
      oe  = (ph < 2'd2);
      qp  = (pos == 0);
      fp  = (pos == 0) && (ph == 2'd0);
      rs  = (ph == 2'd2) && (pos == 2);
      return {oe, ph, qp, fp, rs, 1'b0};
   endfunction

   task automatic test_reset();
      logic [6:0] e;
      e = 7'd0;
      #3;
      chk_cnt++;
      if (obs !== e) $display("FAIL reset_hold obs=%b exp=%b", obs, e);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (obs !== e) $display("FAIL reset_release_idle obs=%b exp=%b", obs, e);
      else pass_cnt++;
      $display("test_reset done: %0d/%0d", pass_cnt, chk_cnt);
   endtask

   task automatic test_basic(input int div, input int q, input string name);
      logic [6:0] e;
      en = 1'b0; stretch_en = 1'b1; scl_low = 1'b0;
      div_cfg = 16'(div);
      repeat (3) @(negedge clk);
      en = 1'b1;
      for (int k = 0; k < 4 * q * 2; k++) begin
         @(negedge clk);
         e = exp_norm(k, q);
         chk_cnt++;
         if (obs !== e) $display("FAIL %s k=%0d obs=%b exp=%b", name, k, obs, e);
         else pass_cnt++;
      end
      en = 1'b0;
      $display("test_%s div_cfg=%0d quarter=%0d done: %0d/%0d", name, div, q, pass_cnt, chk_cnt);
   endtask

   task automatic test_stretch();
      logic [6:0] e;
      en = 1'b0; stretch_en = 1'b1; scl_low = 1'b1;
      div_cfg = 16'd3;
      repeat (3) @(negedge clk);
      en = 1'b1;
      for (int k = 0; k < 48; k++) begin
         @(negedge clk);
         if (k < 8) begin
            e = exp_norm(k, 4);
         end else if (k < 32) begin
            e      = 7'd0;
            e[5:4] = 2'd2;
            e[3]   = (k == 8);
            e[1]   = (k == 30);
            e[0]   = (k >= 10) && (k <= 29);
         end else begin
            e = exp_norm(k - 20, 4);
         end
         chk_cnt++;
         if (obs !== e) $display("FAIL stretch k=%0d obs=%b exp=%b", k, obs, e);
         else pass_cnt++;
         if (k == 28) scl_low = 1'b0;
      end
      en = 1'b0;
      $display("test_stretch done: %0d/%0d", pass_cnt, chk_cnt);
   endtask

   task automatic test_div_change();
      logic [6:0] e;
      en = 1'b0; stretch_en = 1'b1; scl_low = 1'b0;
      div_cfg = 16'd3;
      repeat (3) @(negedge clk);
      en = 1'b1;
      for (int k = 0; k < 48; k++) begin
         @(negedge clk);
         e = (k < 16) ? exp_norm(k, 4) : exp_norm(k - 16, 8);
         chk_cnt++;
         if (obs !== e) $display("FAIL div_change k=%0d obs=%b exp=%b", k, obs, e);
         else pass_cnt++;
         if (k == 5) div_cfg = 16'd7;
      end
      en = 1'b0;
      $display("test_div_change done: %0d/%0d", pass_cnt, chk_cnt);
   endtask

   task automatic test_en_drop();
      logic [6:0] e;
      // Drop in phase 2 without stretching.
      en = 1'b0; stretch_en = 1'b0; scl_low = 1'b0;
      div_cfg = 16'd3;
      repeat (3) @(negedge clk);
      en = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         e = (k < 10) ? exp_norm(k, 4) : 7'd0;
         chk_cnt++;
         if (obs !== e) $display("FAIL en_drop k=%0d obs=%b exp=%b", k, obs, e);
         else pass_cnt++;
         if (k == 9) en = 1'b0;
      end
      // Drop in the middle of a stretch.
      stretch_en = 1'b1; scl_low = 1'b1;
      repeat (2) @(negedge clk);
      en = 1'b1;
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         if (k < 8) begin
            e = exp_norm(k, 4);
         end else if (k < 16) begin
            e      = 7'd0;
            e[5:4] = 2'd2;
            e[3]   = (k == 8);
            e[0]   = (k >= 10);
         end else begin
            e = 7'd0;
         end
         chk_cnt++;
         if (obs !== e) $display("FAIL en_drop_stretch k=%0d obs=%b exp=%b", k, obs, e);
         else pass_cnt++;
         if (k == 15) en = 1'b0;
      end
      // Restart cleanly after the abort.
      scl_low = 1'b0;
      repeat (2) @(negedge clk);
      en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         e = exp_norm(k, 4);
         chk_cnt++;
         if (obs !== e) $display("FAIL en_restart k=%0d obs=%b exp=%b", k, obs, e);
         else pass_cnt++;
      end
      en = 1'b0;
      $display("test_en_drop done: %0d/%0d", pass_cnt, chk_cnt);
   endtask

   task automatic test_async_reset();
      logic [6:0] e;
      en = 1'b0; stretch_en = 1'b0; scl_low = 1'b0;
      div_cfg = 16'd3;
      repeat (3) @(negedge clk);
      en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         e = exp_norm(k, 4);
         chk_cnt++;
         if (obs !== e) $display("FAIL pre_reset k=%0d obs=%b exp=%b", k, obs, e);
         else pass_cnt++;
      end
      // Mid-cycle reset, away from any clock edge.
      #2 rst_n = 1'b0;
      #1;
      e = 7'd0;
      chk_cnt++;
      if (obs !== e) $display("FAIL async_reset_immediate obs=%b exp=%b", obs, e);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (obs !== e) $display("FAIL async_reset_held obs=%b exp=%b", obs, e);
      else pass_cnt++;
      // Release with en still high: the run starts on the reset divider (124).
      #2 rst_n = 1'b1;
      for (int k = 0; k < 130; k++) begin
         @(negedge clk);
         e = exp_norm(k, 125);
         chk_cnt++;
         if (obs !== e) $display("FAIL reset_default_div k=%0d obs=%b exp=%b", k, obs, e);
         else pass_cnt++;
      end
      en = 1'b0;
      $display("test_async_reset done: %0d/%0d", pass_cnt, chk_cnt);
   endtask

   initial begin
      pass_cnt   = 0;
      chk_cnt    = 0;
      rst_n      = 1'b0;
      en         = 1'b0;
      div_cfg    = 16'd3;
      stretch_en = 1'b0;
      scl_low    = 1'b0;
      test_reset();
      test_basic(3, 4, "basic_div3");
      test_basic(0, 3, "clamp_div0");
      test_stretch();
      test_div_change();
      test_en_drop();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule : tb_iic_scl_timing_gen
